spi_cfg_sequencer: RTL and testbench
====================================

# spi_cfg_sequencer

AXI-domain sequencer that owns the shim SPI enable and the configuration words feeding the configuration CDC synchronizers. It validates the requested configuration and freezes it while the SPI domain runs. It holds enable off until the latched words have had time to cross the clock boundary. On disable it waits for the SPI domain to report idle, with a timeout, before unlocking configuration.

## Interface
Parameters:
- SETTLE_CYCLES, 16: aclk cycles between config latch and spi_en assertion; ≥1 and ≥ coherent-sync handshake latency.
- DRAIN_HOLD, 8: cycles after spi_en deassertion during which spi_off is ignored (covers enable synchronizer depth).
- DRAIN_TIMEOUT, 1024: max cycles in DRAIN before fault; > DRAIN_HOLD.

Ports:
- aclk  in  1  system clock; the only clock.
- areset  in  1  asynchronous, active-high reset.
- en_req  in  1  software enable request (level).
- spi_off  in  1  SPI domain idle, already synchronized to aclk.
- integ_thresh_avg / integ_window / integ_en / dac_n_cs_high_time / adc_n_cs_high_time / dac_cal_init  in  15/32/1/5/8/16  requested config (dac_cal_init signed).
- *_out (same six names)  out  same widths  latched config to synchronizers.
- spi_en  out  1  enable to SPI-domain sync.
- block_bufs  out  1  buffer block to SPI-domain sync.
- state  out  3  IDLE=0, LATCH=1, SETTLE=2, RUN=3, DRAIN=4, HALT=5.
- cfg_locked  out  1  high in LATCH, SETTLE, RUN, DRAIN, HALT.
- err_code  out  2  0 none, 1 invalid config, 2 drain timeout; sticky.
- cfg_change_err  out  1  sticky: input config changed while locked.

## Operation
- Reset values: state IDLE, spi_en 0, block_bufs 1, err_code 0, cfg_change_err 0, cfg_locked 0, integ_thresh_avg_out 0x1000, integ_window_out 0x00010000, integ_en_out 0, dac_n_cs_high_time_out 31, adc_n_cs_high_time_out 255, dac_cal_init_out 0.
- IDLE: *_out load inputs every cycle (transparent, registered). block_bufs 1.
- Invalid config: adc_n_cs_high_time==0, or integ_en==1 with integ_window==0 or integ_thresh_avg==0.
- IDLE & en_req & valid: go to LATCH and capture config. Clear err_code and cfg_change_err.
- IDLE & en_req & invalid: go to HALT, err_code=1, *_out hold.
- LATCH: one cycle. Load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: counter reaching 0 goes to RUN, else decrement. block_bufs 1.
- RUN: spi_en 1, block_bufs 0.
- In LATCH, SETTLE or RUN with en_req==0: go to DRAIN. spi_en drops on the same edge, block_bufs 1, elapsed counter cleared to 0.
- DRAIN, evaluated in this priority:
  - elapsed ≥ DRAIN_HOLD & spi_off: go to IDLE.
  - elapsed == DRAIN_TIMEOUT-1: go to HALT, err_code=2.
  - Otherwise increment elapsed.
- HALT: spi_en 0, block_bufs 1, *_out hold. en_req==0 returns to IDLE.
- en_req reasserted during DRAIN or HALT is ignored. A restart requires passing through IDLE.
- While locked, any *_in ≠ *_out sets cfg_change_err. *_out never change while locked.
- areset mid-operation: all outputs take reset values immediately, with no drain.

## Timing
- All outputs are registered; spi_en = registered (next_state==RUN).
- Let N be the edge that samples en_req=1 in IDLE with valid config:
  - LATCH from N.
  - SETTLE from N+1.
  - spi_en rises at edge N+SETTLE_CYCLES+1.
- Let M be the edge that samples en_req=0 in RUN:
  - spi_en falls at M.
  - Earliest IDLE at M+DRAIN_HOLD+1.
  - Timeout HALT at M+DRAIN_TIMEOUT.
- Config captured at N equals the inputs present at N. These values stay stable on *_out from N until IDLE is re-entered.

## Test plan
- Reset, then idle: outputs at defaults. Drive integ_window=0x200: integ_window_out=0x200 one edge later, spi_en 0, block_bufs 1.
- SETTLE_CYCLES=4, valid config, en_req 0→1 sampled at edge N: state LATCH at N, spi_en=1 exactly at N+5, block_bufs 0 at N+5.
- In RUN, change dac_cal_init from 0 to 100: dac_cal_init_out stays 0, cfg_change_err=1. Drop en_req, spi_off=1 throughout: spi_en 0 at once, IDLE at M+9, dac_cal_init_out=100 next edge.
- integ_en=1, integ_window=0, en_req=1: HALT, err_code=1, spi_en never 1. en_req=0 gives IDLE. A valid retry reaches RUN with err_code cleared.
- DRAIN_TIMEOUT=32, spi_off held 0 after disable: HALT at M+32, err_code=2. Pulse spi_off=1 at elapsed=3 (<DRAIN_HOLD): ignored.
- areset asserted mid-SETTLE and mid-RUN: spi_en 0, state 0, all *_out at defaults asynchronously.

Source files
------------

// File: rtl/spi_cfg_sequencer.sv
// AXI-domain sequencer for the shim SPI enable: validates, latches and freezes
// configuration, delays enable for CDC settling, and drains with timeout on disable.
module spi_cfg_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned DRAIN_HOLD    = 8,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               en_req,
  input  logic               spi_off,
  input  logic [14:0]        integ_thresh_avg,
  input  logic [31:0]        integ_window,
  input  logic               integ_en,
  input  logic [4:0]         dac_n_cs_high_time,
  input  logic [7:0]         adc_n_cs_high_time,
  input  logic signed [15:0] dac_cal_init,
  output logic [14:0]        integ_thresh_avg_out,
  output logic [31:0]        integ_window_out,
  output logic               integ_en_out,
  output logic [4:0]         dac_n_cs_high_time_out,
  output logic [7:0]         adc_n_cs_high_time_out,
  output logic signed [15:0] dac_cal_init_out,
  output logic               spi_en,
  output logic               block_bufs,
  output logic [2:0]         state,
  output logic               cfg_locked,
  output logic [1:0]         err_code,
  output logic               cfg_change_err
);

  localparam int unsigned CNT_MAX = (DRAIN_TIMEOUT > SETTLE_CYCLES) ? DRAIN_TIMEOUT : SETTLE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic [14:0]        integ_thresh_avg;
    logic [31:0]        integ_window;
    logic               integ_en;
    logic [4:0]         dac_n_cs_high_time;
    logic [7:0]         adc_n_cs_high_time;
    logic signed [15:0] dac_cal_init;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    integ_thresh_avg:   15'h1000,
    integ_window:       32'h0001_0000,
    integ_en:           1'b0,
    dac_n_cs_high_time: 5'd31,
    adc_n_cs_high_time: 8'd255,
    dac_cal_init:       16'sd0
  };

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  cfg_t          cfg_q, cfg_n, cfg_in;
  logic [1:0]    err_q, err_n;
  logic          chg_q, chg_n;
  logic          cfg_valid;

  assign cfg_in = {integ_thresh_avg, integ_window, integ_en,
                   dac_n_cs_high_time, adc_n_cs_high_time, dac_cal_init};

  assign cfg_valid = !((adc_n_cs_high_time == 8'd0) ||
                       (integ_en && ((integ_window == 32'd0) || (integ_thresh_avg == 15'd0))));

  // Next-state, counter, config-hold and sticky-error logic
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    cfg_n   = cfg_q;
    err_n   = err_q;
    chg_n   = chg_q;
    if (state_q != S_IDLE && cfg_in != cfg_q) chg_n = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (en_req && !cfg_valid) begin
          state_n = S_HALT;
          err_n   = 2'd1;
        end else begin
          cfg_n = cfg_in;
          if (en_req) begin
            state_n = S_LATCH;
            err_n   = 2'd0;
            chg_n   = 1'b0;
          end
        end
      end
      S_LATCH: begin
        if (!en_req) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          state_n = S_SETTLE;
          cnt_n   = CW'(SETTLE_CYCLES - 1);
        end
      end
      S_SETTLE: begin
        if (!en_req) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else if (cnt_q == '0) begin
          state_n = S_RUN;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      S_RUN: begin
        if (!en_req) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end
      end
      S_DRAIN: begin
        // spi_off is stale until the enable synchronizer has flushed
        if (cnt_q >= CW'(DRAIN_HOLD) && spi_off) begin
          state_n = S_IDLE;
        end else if (cnt_q == CW'(DRAIN_TIMEOUT - 1)) begin
          state_n = S_HALT;
          err_n   = 2'd2;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      S_HALT: begin
        if (!en_req) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Dedicated flops for CDC-bound controls so they never glitch on state decode
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cfg_q      <= CFG_RST;
      err_q      <= 2'd0;
      chg_q      <= 1'b0;
      spi_en     <= 1'b0;
      block_bufs <= 1'b1;
      cfg_locked <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      cfg_q      <= cfg_n;
      err_q      <= err_n;
      chg_q      <= chg_n;
      spi_en     <= (state_n == S_RUN);
      block_bufs <= (state_n != S_RUN);
      cfg_locked <= (state_n != S_IDLE);
    end
  end

  assign state                  = state_q;
  assign err_code               = err_q;
  assign cfg_change_err         = chg_q;
  assign integ_thresh_avg_out   = cfg_q.integ_thresh_avg;
  assign integ_window_out       = cfg_q.integ_window;
  assign integ_en_out           = cfg_q.integ_en;
  assign dac_n_cs_high_time_out = cfg_q.dac_n_cs_high_time;
  assign adc_n_cs_high_time_out = cfg_q.adc_n_cs_high_time;
  assign dac_cal_init_out       = cfg_q.dac_cal_init;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Scoreboard bench for spi_cfg_sequencer: an edge-timestamp reference model queues
// the expected output snapshot per clock; a monitor compares on the falling edge.
module tb_spi_cfg_sequencer;

  localparam int SETTLE = 4;
  localparam int DHOLD  = 8;
  localparam int DTOUT  = 32;

  typedef struct packed {
    logic [14:0] ta;
    logic [31:0] w;
    logic        ie;
    logic [4:0]  dh;
    logic [7:0]  ah;
    logic [15:0] dc;
  } cfg_t;

  typedef struct packed {
    logic [2:0] st;
    logic       en;
    logic       bb;
    logic       lk;
    logic [1:0] err;
    logic       chg;
    cfg_t       cfg;
  } snap_t;

  localparam cfg_t DEF_CFG = '{ta: 15'h1000, w: 32'h0001_0000, ie: 1'b0, dh: 5'd31, ah: 8'd255, dc: 16'd0};

  logic               aclk = 1'b0;
  logic               areset = 1'b1;
  logic               en_req = 1'b0;
  logic               spi_off = 1'b0;
  logic [14:0]        integ_thresh_avg = 15'h1000;
  logic [31:0]        integ_window = 32'h0001_0000;
  logic               integ_en = 1'b0;
  logic [4:0]         dac_n_cs_high_time = 5'd31;
  logic [7:0]         adc_n_cs_high_time = 8'd255;
  logic signed [15:0] dac_cal_init = 16'sd0;
  logic [14:0]        integ_thresh_avg_out;
  logic [31:0]        integ_window_out;
  logic               integ_en_out;
  logic [4:0]         dac_n_cs_high_time_out;
  logic [7:0]         adc_n_cs_high_time_out;
  logic signed [15:0] dac_cal_init_out;
  logic               spi_en, block_bufs, cfg_locked, cfg_change_err;
  logic [2:0]         state;
  logic [1:0]         err_code;

  int n_pass = 0;
  int n_total = 0;
  snap_t exp_q[$];

  spi_cfg_sequencer #(.SETTLE_CYCLES(SETTLE), .DRAIN_HOLD(DHOLD), .DRAIN_TIMEOUT(DTOUT)) dut (
    .aclk(aclk), .areset(areset), .en_req(en_req), .spi_off(spi_off),
    .integ_thresh_avg(integ_thresh_avg), .integ_window(integ_window), .integ_en(integ_en),
    .dac_n_cs_high_time(dac_n_cs_high_time), .adc_n_cs_high_time(adc_n_cs_high_time),
    .dac_cal_init(dac_cal_init),
    .integ_thresh_avg_out(integ_thresh_avg_out), .integ_window_out(integ_window_out),
    .integ_en_out(integ_en_out), .dac_n_cs_high_time_out(dac_n_cs_high_time_out),
    .adc_n_cs_high_time_out(adc_n_cs_high_time_out), .dac_cal_init_out(dac_cal_init_out),
    .spi_en(spi_en), .block_bufs(block_bufs), .state(state), .cfg_locked(cfg_locked),
    .err_code(err_code), .cfg_change_err(cfg_change_err)
  );

  always #5 aclk = ~aclk;

  function automatic snap_t mk_snap(int ph, logic [1:0] err, logic chg, cfg_t c);
    snap_t s;
    s.st  = 3'(ph);
    s.en  = (ph == 3);
    s.bb  = (ph != 3);
    s.lk  = (ph != 0);
    s.err = err;
    s.chg = chg;
    s.cfg = c;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s = {state, spi_en, block_bufs, cfg_locked, err_code, cfg_change_err,
         integ_thresh_avg_out, integ_window_out, integ_en_out,
         dac_n_cs_high_time_out, adc_n_cs_high_time_out, dac_cal_init_out};
    return s;
  endfunction

  // Reference model: phases tracked by edge timestamps of latch and disable
  initial begin
    int ph, edge_no, t_latch, t_drain;
    cfg_t mcfg, cin;
    logic [1:0] merr;
    logic mchg;
    ph = 0; edge_no = 0; t_latch = 0; t_drain = 0;
    mcfg = DEF_CFG; merr = 2'd0; mchg = 1'b0;
    forever begin
      @(posedge aclk or posedge areset);
      if (areset) begin
        ph = 0; edge_no = 0; mcfg = DEF_CFG; merr = 2'd0; mchg = 1'b0;
        exp_q.delete();
      end else begin
        edge_no++;
        cin = {integ_thresh_avg, integ_window, integ_en, dac_n_cs_high_time,
               adc_n_cs_high_time, dac_cal_init};
        if (ph != 0 && cin != mcfg) mchg = 1'b1;
        case (ph)
          0: begin
            if (!en_req) mcfg = cin;
            else if (cin.ah == 0 || (cin.ie && (cin.w == 0 || cin.ta == 0))) begin
              ph = 5; merr = 2'd1;
            end else begin
              ph = 1; t_latch = edge_no; mcfg = cin; merr = 2'd0; mchg = 1'b0;
            end
          end
          1, 2, 3: begin
            if (!en_req) begin ph = 4; t_drain = edge_no; end
            else if (ph == 1) ph = 2;
            else if (ph == 2 && edge_no == t_latch + SETTLE + 1) ph = 3;
          end
          4: begin
            if (edge_no - t_drain - 1 >= DHOLD && spi_off) ph = 0;
            else if (edge_no - t_drain == DTOUT) begin ph = 5; merr = 2'd2; end
          end
          default: if (!en_req) ph = 0;
        endcase
      end
      exp_q.push_back(mk_snap(ph, merr, mchg, mcfg));
    end
  end

  // Monitor: one expected snapshot per cycle, compared away from the active edge
  initial begin
    snap_t e, a;
    forever begin
      @(negedge aclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_snap();
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL cycle_snapshot t=%0t got st=%0d en=%b bb=%b lk=%b err=%0d chg=%b cfg=%h exp st=%0d en=%b bb=%b lk=%b err=%0d chg=%b cfg=%h",
                      $time, a.st, a.en, a.bb, a.lk, a.err, a.chg, a.cfg,
                      e.st, e.en, e.bb, e.lk, e.err, e.chg, e.cfg);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic set_cfg(cfg_t c);
    integ_thresh_avg = c.ta; integ_window = c.w; integ_en = c.ie;
    dac_n_cs_high_time = c.dh; adc_n_cs_high_time = c.ah; dac_cal_init = c.dc;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.ta = ($urandom % 4 == 0) ? 15'd0 : 15'($urandom);
    c.w  = ($urandom % 4 == 0) ? 32'd0 : $urandom;
    c.ie = 1'($urandom);
    c.dh = 5'($urandom);
    c.ah = ($urandom % 6 == 0) ? 8'd0 : 8'($urandom);
    c.dc = 16'($urandom);
    return c;
  endfunction

  task automatic reset_pulse_check(string tag);
    snap_t a, e;
    @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    a = dut_snap();
    e = mk_snap(0, 2'd0, 1'b0, DEF_CFG);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL async_reset_%s got=%h exp=%h", tag, a, e);
    en_req = 1'b0;
    cyc(2);
    areset = 1'b0;
  endtask

  initial begin
    cfg_t c;
    cyc(3);
    areset = 1'b0;
    cyc(2);
    integ_window = 32'h200;
    cyc(3);
    // enable, then change config while running, then disable with spi_off high
    c = '{ta: 15'h40, w: 32'h200, ie: 1'b1, dh: 5'd3, ah: 8'd7, dc: 16'd0};
    set_cfg(c);
    cyc(1);
    en_req = 1'b1;
    cyc(10);
    dac_cal_init = 16'sd100;
    cyc(3);
    spi_off = 1'b1;
    en_req = 1'b0;
    cyc(14);
    // invalid config goes to HALT, then valid retry
    integ_window = 32'd0;
    en_req = 1'b1;
    cyc(5);
    en_req = 1'b0;
    cyc(2);
    integ_window = 32'h55;
    en_req = 1'b1;
    cyc(10);
    adc_n_cs_high_time = 8'd0;
    cyc(2);
    adc_n_cs_high_time = 8'd7;
    en_req = 1'b0;
    cyc(12);
    // drain timeout with an early spi_off pulse inside the hold window
    spi_off = 1'b0;
    en_req = 1'b1;
    cyc(10);
    en_req = 1'b0;
    cyc(4);
    spi_off = 1'b1;
    cyc(1);
    spi_off = 1'b0;
    cyc(10);
    en_req = 1'b1;
    cyc(25);
    en_req = 1'b0;
    cyc(3);
    // asynchronous reset mid-SETTLE and mid-RUN
    spi_off = 1'b1;
    en_req = 1'b1;
    cyc(2);
    reset_pulse_check("settle");
    en_req = 1'b1;
    cyc(9);
    reset_pulse_check("run");
    cyc(2);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      cyc(1);
      if ($urandom % 16 == 0) en_req = ~en_req;
      if ($urandom % 8 == 0) spi_off = ~spi_off;
      if ($urandom % 12 == 0) set_cfg(rand_cfg());
    end
    en_req = 1'b0;
    spi_off = 1'b1;
    cyc(60);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
